// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// cp0_exc_ctrl
//
// Coprocessor-0 exception/interrupt controller for a 5-stage MIPS-style
// pipeline. It holds the three architecturally visible CP0 registers:
//   SR    (12) : IM[15:10], EXL[1], IE[0]
//   Cause (13) : BD[31], IP[15:10], ExcCode[6:2]   (not writable by mtc0)
//   EPC   (14) : 32-bit exception return address
//
// It also decides, in the same cycle, whether the M-stage instruction must be
// flushed and the pipeline redirected to the handler.
//
// Ports
//   clk        in   1   clock; all state updates on the rising edge
//   reset      in   1   synchronous, active-high reset
//   en         in   1   mtc0 write strobe (M stage)
//   CP0Add     in   5   register index for mfc0/mtc0
//   CP0In      in  32   mtc0 write data
//   VPC        in  32   PC of the M-stage instruction
//   BDIn       in   1   M-stage instruction sits in a branch delay slot
//   ExcCodeIn  in   5   M-stage exception code, 0 = none
//   HWInt      in   6   level-sensitive external interrupt lines
//   EXLClr     in   1   eret in M stage
//   CP0Out     out 32   combinational read of CP0Add
//   EPCOut     out 32   current EPC (eret target)
//   Req        out  1   take exception/interrupt: flush and redirect
//   ReqPC      out 32   handler entry address
// ============================================================================
module cp0_exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0Add,
   input  logic [31:0] CP0In,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] CP0Out,
   output logic [31:0] EPCOut,
   output logic        Req,
   output logic [31:0] ReqPC
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;

   // ------------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------------
   logic [5:0]  im_q,      im_d;
   logic        exl_q,     exl_d;
   logic        ie_q,      ie_d;
   logic        bd_q,      bd_d;
   logic [5:0]  ip_q,      ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q,     epc_d;

   logic        int_req_s;
   logic        exc_req_s;
   logic        req_s;
   logic [31:0] sr_s;
   logic [31:0] cause_s;

   // Only IM/EXL/IE are taken from mtc0 data; the rest of the word is dropped.
   logic        cp0in_unused_s;
   assign cp0in_unused_s = ^{CP0In[31:16], CP0In[9:2]};

   // ------------------------------------------------------------------------
   // Request decision. EXL masks both sources, so a handler is never
   // re-entered. The request is also held low while reset is asserted so
   // the pipeline is not redirected by stale M-stage inputs.
   // ------------------------------------------------------------------------
   assign int_req_s = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_req_s = (ExcCodeIn != 5'd0) & ~exl_q;
   assign req_s     = (int_req_s | exc_req_s) & ~reset;

   assign Req   = req_s;
   assign ReqPC = HANDLER_PC;

   // ------------------------------------------------------------------------
   // Register images as seen by mfc0
   // ------------------------------------------------------------------------
   assign sr_s    = {16'd0, im_q, 8'd0, exl_q, ie_q};
   assign cause_s = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};

   // Read mux: pre-edge register values, no bypass of a same-cycle write.
   always_comb begin
      CP0Out = 32'd0;
      case (CP0Add)
         ADDR_SR:    CP0Out = sr_s;
         ADDR_CAUSE: CP0Out = cause_s;
         ADDR_EPC:   CP0Out = epc_q;
         default:    CP0Out = 32'd0;
      endcase
   end

   assign EPCOut = epc_q;

   // Next-state logic for all CP0 state.
   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      // Pending lines are sampled every cycle, independent of everything else.
      ip_d      = HWInt;

      if (req_s) begin
         // Taking the exception: the M-stage instruction is flushed, so any
         // mtc0 or eret it carries has no effect.
         exl_d     = 1'b1;
         bd_d      = BDIn;
         // An interrupt takes precedence and is recorded as code 0.
         exccode_d = int_req_s ? 5'd0 : ExcCodeIn;
         // A delay-slot victim resumes at its branch; wraps modulo 2^32.
         epc_d     = BDIn ? (VPC - 32'd4) : VPC;
      end else begin
         if (en) begin
            case (CP0Add)
               ADDR_SR: begin
                  im_d  = CP0In[15:10];
                  exl_d = CP0In[1];
                  ie_d  = CP0In[0];
               end
               ADDR_EPC: begin
                  epc_d = CP0In;
               end
               default: begin
                  epc_d = epc_q;
               end
            endcase
         end else begin
            epc_d = epc_q;
         end
         // eret clears EXL even if an mtc0 to SR in the same cycle set it.
         if (EXLClr) begin
            exl_d = 1'b0;
         end else begin
            exl_d = exl_d;
         end
      end
   end

   // State register with synchronous reset taking priority over all updates.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q      <= 6'd0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= 6'd0;
         exccode_q <= 5'd0;
         epc_q     <= 32'd0;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// tb_cp0_exc_ctrl
//
// Directed, table-driven bench for cp0_exc_ctrl. Each table row gives the
// inputs for one clock cycle, the expected Req in that cycle, and the
// expected SR / Cause / EPC after the rising edge. A few hand-written
// sequences cover read-during-write and unmapped-address reads.
// ============================================================================
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] CP0Out;
   logic [31:0] EPCOut;
   logic        Req;
   logic [31:0] ReqPC;

   int total;
   int bad;

   cp0_exc_ctrl #(.HANDLER_PC(32'h0000_4180)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .CP0Add    (CP0Add),
      .CP0In     (CP0In),
      .VPC       (VPC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .CP0Out    (CP0Out),
      .EPCOut    (EPCOut),
      .Req       (Req),
      .ReqPC     (ReqPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [4:0]  addr;
      logic [31:0] din;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        clr;
      logic        req;
      logic [31:0] sr;
      logic [31:0] cause;
      logic [31:0] epc;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic        rst,
      input logic        en_v,
      input logic [4:0]  addr,
      input logic [31:0] din,
      input logic [31:0] vpc,
      input logic        bd,
      input logic [4:0]  exc,
      input logic [5:0]  hw,
      input logic        clr,
      input logic        req,
      input logic [31:0] sr,
      input logic [31:0] cause,
      input logic [31:0] epc
   );
      vec_t v;
      v.rst = rst;   v.en = en_v;  v.addr = addr; v.din = din;
      v.vpc = vpc;   v.bd = bd;    v.exc = exc;   v.hw = hw;
      v.clr = clr;   v.req = req;  v.sr = sr;     v.cause = cause;
      v.epc = epc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset     = v.rst;
      en        = v.en;
      CP0Add    = v.addr;
      CP0In     = v.din;
      VPC       = v.vpc;
      BDIn      = v.bd;
      ExcCodeIn = v.exc;
      HWInt     = v.hw;
      EXLClr    = v.clr;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
      CP0Add = a;
      #1;
      d = CP0Out;
   endtask

   initial begin
      logic [31:0] rd;

      //            rst en addr   din            vpc            bd exc    hw         clr  req  sr             cause          epc
      vecs[0]  = mk(1, 0, 5'd0,  32'h0,         32'h0,         0, 5'd4,  6'b000001, 0,   0,   32'h0,         32'h0,         32'h0);
      vecs[1]  = mk(0, 1, 5'd12, 32'h0000_0401, 32'h0,         0, 5'd0,  6'b000000, 0,   0,   32'h0000_0401, 32'h0,         32'h0);
      vecs[2]  = mk(0, 0, 5'd0,  32'h0,         32'h0000_1000, 0, 5'd0,  6'b000001, 0,   1,   32'h0000_0403, 32'h0000_0400, 32'h0000_1000);
      vecs[3]  = mk(0, 0, 5'd0,  32'h0,         32'h0000_1100, 0, 5'd10, 6'b000001, 0,   0,   32'h0000_0403, 32'h0000_0400, 32'h0000_1000);
      vecs[4]  = mk(0, 0, 5'd0,  32'h0,         32'h0,         0, 5'd0,  6'b000001, 1,   0,   32'h0000_0401, 32'h0000_0400, 32'h0000_1000);
      vecs[5]  = mk(0, 0, 5'd0,  32'h0,         32'h0000_2000, 0, 5'd0,  6'b000001, 0,   1,   32'h0000_0403, 32'h0000_0400, 32'h0000_2000);
      vecs[6]  = mk(0, 1, 5'd12, 32'h0000_0003, 32'h0,         0, 5'd0,  6'b000000, 1,   0,   32'h0000_0001, 32'h0,         32'h0000_2000);
      vecs[7]  = mk(0, 0, 5'd0,  32'h0,         32'h0000_3010, 1, 5'd4,  6'b000000, 0,   1,   32'h0000_0003, 32'h8000_0010, 32'h0000_300C);
      vecs[8]  = mk(0, 0, 5'd0,  32'h0,         32'h0,         0, 5'd0,  6'b000000, 1,   0,   32'h0000_0001, 32'h8000_0010, 32'h0000_300C);
      vecs[9]  = mk(0, 1, 5'd14, 32'h0000_3abc, 32'h0000_4000, 0, 5'd12, 6'b000000, 0,   1,   32'h0000_0003, 32'h0000_0030, 32'h0000_4000);
      vecs[10] = mk(0, 0, 5'd0,  32'h0,         32'h0,         0, 5'd0,  6'b000000, 1,   0,   32'h0000_0001, 32'h0000_0030, 32'h0000_4000);
      vecs[11] = mk(0, 0, 5'd0,  32'h0,         32'h0000_5000, 0, 5'd8,  6'b000000, 1,   1,   32'h0000_0003, 32'h0000_0020, 32'h0000_5000);
      vecs[12] = mk(0, 0, 5'd0,  32'h0,         32'h0,         0, 5'd0,  6'b000000, 1,   0,   32'h0000_0001, 32'h0000_0020, 32'h0000_5000);
      vecs[13] = mk(0, 0, 5'd0,  32'h0,         32'h0,         0, 5'd0,  6'b111111, 0,   0,   32'h0000_0001, 32'h0000_FC20, 32'h0000_5000);
      vecs[14] = mk(0, 1, 5'd12, 32'h0000_FC01, 32'h0,         0, 5'd0,  6'b000000, 0,   0,   32'h0000_FC01, 32'h0000_0020, 32'h0000_5000);
      vecs[15] = mk(0, 0, 5'd0,  32'h0,         32'h0000_6000, 1, 5'd12, 6'b100000, 0,   1,   32'h0000_FC03, 32'h8000_8000, 32'h0000_5FFC);
      vecs[16] = mk(1, 0, 5'd0,  32'h0,         32'h0,         0, 5'd4,  6'b111111, 1,   0,   32'h0,         32'h0,         32'h0);
      vecs[17] = mk(0, 1, 5'd14, 32'h1234_5678, 32'h0,         0, 5'd0,  6'b000000, 0,   0,   32'h0,         32'h0,         32'h1234_5678);
      vecs[18] = mk(0, 1, 5'd13, 32'hFFFF_FFFF, 32'h0,         0, 5'd0,  6'b000000, 0,   0,   32'h0,         32'h0,         32'h1234_5678);
      vecs[19] = mk(0, 0, 5'd0,  32'h0,         32'h0,         1, 5'd4,  6'b000000, 0,   1,   32'h0000_0002, 32'h8000_0010, 32'hFFFF_FFFC);
      vecs[20] = mk(0, 1, 5'd12, 32'hFFFF_FFFF, 32'h0,         0, 5'd0,  6'b000000, 0,   0,   32'h0000_FC03, 32'h8000_0010, 32'hFFFF_FFFC);

      total = 0;
      bad   = 0;
      drive(vecs[0]);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d_req", i), {31'd0, Req}, {31'd0, vecs[i].req});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_epcout", i), EPCOut, vecs[i].epc);
         read_reg(5'd12, rd);
         check($sformatf("v%0d_sr", i), rd, vecs[i].sr);
         read_reg(5'd13, rd);
         check($sformatf("v%0d_cause", i), rd, vecs[i].cause);
         read_reg(5'd14, rd);
         check($sformatf("v%0d_epc", i), rd, vecs[i].epc);
      end

      check("reqpc", ReqPC, 32'h0000_4180);

      // Read-during-write shows the old EPC; new value visible after the edge.
      @(negedge clk);
      drive(mk(1, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 6'b000000, 0, 0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      drive(mk(0, 1, 5'd14, 32'hAAAA_5555, 32'h0, 0, 5'd0, 6'b000000, 0, 0, 32'h0, 32'h0, 32'h0));
      #1;
      check("rdw_epc_old", CP0Out, 32'h0);
      check("rdw_epcout_old", EPCOut, 32'h0);
      @(posedge clk);
      #1;
      check("rdw_epcout_new", EPCOut, 32'hAAAA_5555);
      read_reg(5'd5, rd);
      check("unmapped_5", rd, 32'h0);
      read_reg(5'd15, rd);
      check("unmapped_15", rd, 32'h0);

      // mtc0 to SR read back in the same cycle returns the old SR.
      @(negedge clk);
      drive(mk(0, 1, 5'd12, 32'h0000_0401, 32'h0, 0, 5'd0, 6'b000000, 0, 0, 32'h0, 32'h0, 32'h0));
      #1;
      check("rdw_sr_old", CP0Out, 32'h0);
      check("rdw_sr_noreq", {31'd0, Req}, 32'd0);
      @(posedge clk);
      #1;
      check("rdw_sr_new", CP0Out, 32'h0000_0401);
      // Enabled interrupt now raises Req combinationally in the same cycle.
      @(negedge clk);
      drive(mk(0, 0, 5'd0, 32'h0, 32'h0000_7000, 0, 5'd0, 6'b000001, 0, 0, 32'h0, 32'h0, 32'h0));
      #1;
      check("int_req_same_cycle", {31'd0, Req}, 32'd1);
      @(posedge clk);
      #1;
      check("int_epc", EPCOut, 32'h0000_7000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter: HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address driven on ReqPC.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  mtc0 write strobe from M stage.
REQ-005 CP0Add  in  5  register index for read/write (12=SR, 13=Cause, 14=EPC).
REQ-006 CP0In  in  32  mtc0 write data.
REQ-007 VPC  in  32  victim PC of the instruction in M stage.
REQ-008 BDIn  in  1  M-stage instruction is in a delay slot.
REQ-009 ExcCodeIn  in  5  M-stage exception code; 5'd0 = no exception.
REQ-010 HWInt  in  6  external hardware interrupt lines, level-sensitive.
REQ-011 EXLClr  in  1  eret in M stage; clears EXL.
REQ-012 CP0Out  out  32  combinational read of register CP0Add.
REQ-013 EPCOut  out  32  current EPC, combinational.
REQ-014 Req  out  1  take-exception request to the pipeline registers (flush and redirect), combinational.
REQ-015 ReqPC  out  32  constant HANDLER_PC.

Function
REQ-016 SR fields: IM=SR[15:10], EXL=SR[1], IE=SR[0]; all other SR bits read 0.
REQ-017 Cause fields: BD=Cause[31], IP=Cause[15:10], ExcCode=Cause[6:2]; all other bits read 0; Cause is not writable by mtc0.
REQ-018 IntReq = |(HWInt & IM) & IE & ~EXL.
REQ-019 ExcReq = (ExcCodeIn != 0) & ~EXL.
REQ-020 Req = IntReq | ExcReq, same cycle, no register stage.
REQ-021 IP <= HWInt every cycle, regardless of Req, en or EXL.
REQ-022 On posedge with Req=1: EXL<=1; BD<=BDIn; ExcCode<= IntReq ? 5'd0 : ExcCodeIn; EPC<= BDIn ? VPC-4 : VPC, with the subtraction modulo 2^32.
REQ-023 Interrupt wins over a simultaneous synchronous exception; ExcCode records 0.
REQ-024 On posedge with Req=0 and en=1: CP0Add=12 writes IM, EXL, IE from CP0In; CP0Add=14 writes all 32 bits of EPC; other addresses are ignored.
REQ-025 Req=1 suppresses a same-cycle mtc0 write, because the writing instruction is flushed.
REQ-026 EXLClr=1 with Req=0 clears EXL at posedge; if en also targets SR, EXLClr overrides the written EXL bit.
REQ-027 Req=1 and EXLClr=1 in the same cycle: Req wins and EXL becomes 1.
REQ-028 While EXL=1, neither interrupts nor exceptions assert Req (no nesting).
REQ-029 CP0Out returns SR, Cause or EPC for CP0Add 12, 13 or 14, and 0 otherwise.
REQ-030 CP0Out reflects the pre-edge value during a same-cycle write; there is no write-through bypass.
REQ-031 EPCOut equals the EPC register, so the eret target is valid the cycle after EPC is written.

Reset
REQ-032 On reset: SR=0, Cause=0 (including IP), EPC=0.
REQ-033 During reset, Req=0 and CP0Out/EPCOut read 0 at the next cycle; reset has priority over Req, en and EXLClr.
REQ-034 Reset asserted mid-handler (EXL=1) returns EXL to 0.

Verification
REQ-035 Reset, then mtc0 SR=32'h0000_0401 and HWInt=6'b000001 -> Req=1 in the same cycle; after the edge, EXL=1, ExcCode=0, EPC=VPC.
REQ-036 ExcCodeIn=5'd4, BDIn=1, VPC=32'h0000_3010, EXL=0 -> Req=1; after the edge, EPC=32'h0000_300C, BD=1, Cause[6:2]=4.
REQ-037 With EXL=1, HWInt active and ExcCodeIn=5'd10 -> Req=0 and state unchanged; then EXLClr=1 -> EXL=0 and the pending enabled interrupt raises Req on the next cycle.
REQ-038 en=1, CP0Add=14, CP0In=32'h0000_3abc while ExcCodeIn=5'd12 -> EPC=VPC, not 32'h0000_3abc.
REQ-039 IE=1 and IM=0 with HWInt=6'b111111 -> Req=0 and Cause[15:10]=6'b111111 one cycle later.
REQ-040 With VPC=0, BDIn=1 and an exception -> EPC=32'hFFFF_FFFC (wrap-around).
